mod29_sched: RTL and testbench

MOD29_SCHED -- requirements
Module: mod29_sched

---
 rtl/mod29_sched_pkg.sv | 16 +
 rtl/mod29_rr_arb.sv | 38 +++
 rtl/mod29_sched.sv | 127 ++++++++++++
 tb/tb_mod29_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mod29_sched_pkg.sv
// Shared types and sizes for the mod29 request scheduler.
package mod29_sched_pkg;

    localparam int NUM_REQ = 3;
    localparam int OPND_W  = 3;
    localparam int RSP_W   = 5;
    localparam int ID_W    = 2;
    localparam int SCNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mod29_rr_arb.sv
// Round-robin arbiter over three requesters; the search starts just above last_id.
module mod29_rr_arb
    import mod29_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_id_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o
);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] step);
        logic [ID_W:0] s;
        s = {1'b0, base} + {1'b0, step};
        if (s >= 3'(NUM_REQ)) s = s - 3'(NUM_REQ);
        return s[ID_W-1:0];
    endfunction

    logic                found;
    logic [ID_W-1:0]     cand;

    // Step k=NUM_REQ lands back on last_id, so it has the lowest priority.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = wrap_idx(last_id_i, ID_W'(k));
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_id_o    = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod29_sched.sv
// Arbitrates three requesters onto an external shared datapath, waits for it to
// settle, captures the result and hands it out with a valid/ready response.
module mod29_sched
    import mod29_sched_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_flag,
    input  logic [NUM_REQ*OPND_W-1:0] req_opnd,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      dp_flag,
    output logic [OPND_W-1:0]         dp_opnd,
    input  logic                      dp_ob32,
    input  logic [2:0]                dp_ov33,
    input  logic                      dp_ob34,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RSP_W-1:0]          rsp_data,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          txn_cnt
);

    state_e             state_q, state_d;
    logic [SCNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic               flag_q, flag_d;
    logic [OPND_W-1:0]  opnd_q, opnd_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   txn_q, txn_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [OPND_W-1:0]  opnd_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_opnd
        assign opnd_arr[g] = req_opnd[g*OPND_W +: OPND_W];
    end

    mod29_rr_arb u_arb (
        .req_i     (req_valid),
        .last_id_i (last_q),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        last_d     = last_q;
        flag_d     = flag_q;
        opnd_d     = opnd_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        txn_d      = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    id_d    = gnt_id;
                    flag_d  = req_flag[gnt_id];
                    opnd_d  = opnd_arr[gnt_id];
                    cnt_d   = SCNT_W'(SETTLE_CYCLES);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - SCNT_W'(1);
                if (cnt_q == SCNT_W'(1)) begin
                    rsp_data_d = {dp_ob32, dp_ov33, dp_ob34};
                    rsp_id_d   = id_q;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    last_d  = rsp_id_q;
                    txn_d   = txn_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_id resets to 2 so that requester 0 is the first to win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            id_q       <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            flag_q     <= 1'b0;
            opnd_q     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            txn_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            last_q     <= last_d;
            flag_q     <= flag_d;
            opnd_q     <= opnd_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            txn_q      <= txn_d;
        end
    end

    // Grant is combinational, so it is also masked while reset is held.
    assign req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign dp_flag   = flag_q;
    assign dp_opnd   = opnd_q;
    assign txn_cnt   = txn_q;

endmodule

// File: tb/tb_mod29_sched.sv
// Directed bench for mod29_sched with a small external datapath model.
module tb_mod29_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_valid;
    logic [2:0] req_flag;
    logic [8:0] req_opnd;
    logic [2:0] req_ready;
    logic       dp_flag;
    logic [2:0] dp_opnd;
    logic       dp_ob32;
    logic [2:0] dp_ov33;
    logic       dp_ob34;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [4:0] rsp_data;
    logic       rsp_ready;
    logic       busy;
    logic [7:0] txn_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Datapath: flag^opnd[0], opnd+flag, &opnd.
    assign dp_ob32 = dp_flag ^ dp_opnd[0];
    assign dp_ov33 = dp_opnd + {2'b00, dp_flag};
    assign dp_ob34 = &dp_opnd;

    mod29_sched #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_flag  (req_flag),
        .req_opnd  (req_opnd),
        .req_ready (req_ready),
        .dp_flag   (dp_flag),
        .dp_opnd   (dp_opnd),
        .dp_ob32   (dp_ob32),
        .dp_ov33   (dp_ov33),
        .dp_ob34   (dp_ob34),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .txn_cnt   (txn_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with rsp_ready held high: grant, two settle cycles, one response.
    task automatic do_txn(input logic [1:0] id, input logic [4:0] data, input logic [7:0] cnt_after);
        logic [2:0] oh;
        oh = 3'b001 << id;
        chk("txn grant", req_ready, oh);
        tick();
        chk("txn settle1 busy", busy, 1);
        chk("txn settle1 vld", rsp_valid, 0);
        chk("txn settle1 rdy", req_ready, 0);
        tick();
        chk("txn settle2 vld", rsp_valid, 0);
        tick();
        chk("txn resp vld", rsp_valid, 1);
        chk("txn resp id", rsp_id, id);
        chk("txn resp data", rsp_data, data);
        tick();
        chk("txn done vld", rsp_valid, 0);
        chk("txn done busy", busy, 0);
        chk("txn done cnt", txn_cnt, cnt_after);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_flag  = 3'b111;
        req_opnd  = 9'h1FF;
        rsp_ready = 1'b1;
        repeat (2) tick();
        chk("rst req_ready", req_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_id", rsp_id, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst dp_flag", dp_flag, 0);
        chk("rst dp_opnd", dp_opnd, 0);
        chk("rst txn_cnt", txn_cnt, 0);

        req_valid = 3'b000;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        tick();
        chk("idle busy", busy, 0);
        chk("idle cnt", txn_cnt, 0);

        // Single request from requester 1: flag=1, opnd=101
        req_valid = 3'b010;
        req_flag  = 3'b010;
        req_opnd  = 9'b000_101_000;
        #1;
        chk("single grant", req_ready, 3'b010);
        tick();
        chk("single rdy low", req_ready, 0);
        chk("single dp_flag", dp_flag, 1);
        chk("single dp_opnd", dp_opnd, 3'b101);
        chk("single vld t+1", rsp_valid, 0);
        tick();
        chk("single vld t+2", rsp_valid, 0);
        tick();
        chk("single vld t+3", rsp_valid, 1);
        chk("single id", rsp_id, 1);
        chk("single data", rsp_data, 5'd12);

        // Backpressure with new requests and changed operands appearing meanwhile
        req_valid = 3'b111;
        req_flag  = 3'b101;
        req_opnd  = 9'b110_101_011;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp vld", rsp_valid, 1);
            chk("bp id", rsp_id, 1);
            chk("bp data", rsp_data, 5'd12);
            chk("bp no grant", req_ready, 0);
            chk("bp cnt", txn_cnt, 0);
            chk("bp dp_flag", dp_flag, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tick();
        chk("bp done vld", rsp_valid, 0);
        chk("bp done cnt", txn_cnt, 1);

        // Round robin continues after requester 1
        do_txn(2'd2, 5'd30, 8'd2);
        do_txn(2'd0, 5'd8, 8'd3);

        // Abort requester 1 in SETTLE with reset
        tick();
        chk("pre-abort busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort req_ready", req_ready, 0);
        chk("abort busy", busy, 0);
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort rsp_id", rsp_id, 0);
        chk("abort rsp_data", rsp_data, 0);
        chk("abort dp_flag", dp_flag, 0);
        chk("abort dp_opnd", dp_opnd, 0);
        chk("abort txn_cnt", txn_cnt, 0);
        #2;
        rst_n = 1'b1;
        #1;

        // All three continuously valid from reset: 0,1,2,0
        do_txn(2'd0, 5'd8, 8'd1);
        do_txn(2'd1, 5'd26, 8'd2);
        do_txn(2'd2, 5'd30, 8'd3);
        do_txn(2'd0, 5'd8, 8'd4);

        // Drop request and scramble operands during SETTLE
        req_valid = 3'b001;
        #1;
        chk("drop grant", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        req_flag  = 3'b000;
        req_opnd  = 9'h1FF;
        #1;
        chk("drop dp_flag", dp_flag, 1);
        chk("drop dp_opnd", dp_opnd, 3'b011);
        tick();
        tick();
        chk("drop vld", rsp_valid, 1);
        chk("drop id", rsp_id, 0);
        chk("drop data", rsp_data, 5'd8);
        tick();
        chk("drop cnt", txn_cnt, 5);

        repeat (3) tick();
        chk("noreq busy", busy, 0);
        chk("noreq rdy", req_ready, 0);
        chk("noreq cnt", txn_cnt, 5);

        // Counter wrap: 251 more back-to-back transactions at 4 cycles each
        req_valid = 3'b111;
        req_flag  = 3'b101;
        req_opnd  = 9'b110_101_011;
        repeat (250 * 4) tick();
        chk("wrap cnt 255", txn_cnt, 8'd255);
        repeat (4) tick();
        chk("wrap cnt 0", txn_cnt, 8'd0);
        chk("wrap idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
